// File: rtl/axi4_master_cmd_seq.sv
// Command sequencer in front of axi4_master: splits one large transfer request into
// chunks bounded by MAX_CHUNK_WORDS and BOUNDARY_BYTES, triggering the master once per chunk.
module axi4_master_cmd_seq #(
    parameter int ADDR_WIDTH      = 15,
    parameter int USER_DATA_WIDTH = 8,
    parameter int MAX_CHUNK_WORDS = 256,
    parameter int MAX_TOTAL_WORDS = 65535,
    parameter int BOUNDARY_BYTES  = 4096,
    parameter int MSG_WIDTH       = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   i_req_valid,
    output logic                                   o_req_ready,
    input  logic                                   i_req_direction,
    input  logic [ADDR_WIDTH-1:0]                  i_req_base_address,
    input  logic [$clog2(MAX_TOTAL_WORDS+1)-1:0]   i_req_num_words,
    output logic                                   o_busy,
    output logic                                   o_done,
    output logic [MSG_WIDTH-1:0]                   o_msgs,
    input  logic                                   i_master_ready,
    output logic                                   o_master_trigger,
    output logic [$clog2(MAX_CHUNK_WORDS+1)-1:0]   o_master_num_data_words,
    output logic [ADDR_WIDTH-1:0]                  o_master_base_address,
    output logic                                   o_master_direction,
    input  logic [MSG_WIDTH-1:0]                   i_master_msgs,
    output logic                                   o_master_clear_messages
);

    localparam int BPW     = USER_DATA_WIDTH / 8;
    localparam int BPW_LOG = $clog2(BPW);
    localparam int BLOG    = $clog2(BOUNDARY_BYTES);
    localparam int NW      = $clog2(MAX_TOTAL_WORDS + 1);
    localparam int CW      = $clog2(MAX_CHUNK_WORDS + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CALC      = 3'd1;
    localparam logic [2:0] S_TRIGGER   = 3'd2;
    localparam logic [2:0] S_WAIT_BUSY = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [NW-1:0]         r_remaining;
    logic                  r_dir;
    logic                  r_busy;
    logic                  r_done;
    logic [MSG_WIDTH-1:0]  r_msgs;
    logic [CW-1:0]         r_m_num;
    logic [ADDR_WIDTH-1:0] r_m_addr;
    logic                  r_m_dir;

    logic [31:0]           w_room;
    logic [31:0]           w_lim;
    logic [CW-1:0]         w_chunk;
    logic                  w_fire;

    // Chunk = min(remaining, MAX_CHUNK_WORDS, words left before the next boundary).
    // NOTE: every always_comb output gets a default assignment first so no latch is inferred.
    always_comb begin
        w_room = (32'(BOUNDARY_BYTES) - 32'(r_addr[BLOG-1:0])) >> BPW_LOG;
        w_lim  = 32'(r_remaining);
        if (w_lim > 32'(MAX_CHUNK_WORDS)) w_lim = 32'(MAX_CHUNK_WORDS);
        if (w_lim > w_room)               w_lim = w_room;
        w_chunk = CW'(w_lim);
    end

    // Trigger is combinational so it lands in the very cycle the master reports ready.
    assign w_fire = (r_state == S_TRIGGER) && i_master_ready;

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_dir       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_msgs      <= '0;
            r_m_num     <= '0;
            r_m_addr    <= '0;
            r_m_dir     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_addr      <= i_req_base_address;
                        r_remaining <= i_req_num_words;
                        r_dir       <= i_req_direction;
                        r_msgs      <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= (i_req_num_words == '0) ? S_DONE : S_CALC;
                    end
                end
                S_CALC: begin
                    r_m_num  <= w_chunk;
                    r_m_addr <= r_addr;
                    r_m_dir  <= r_dir;
                    r_state  <= S_TRIGGER;
                end
                S_TRIGGER: begin
                    if (w_fire) begin
                        r_addr      <= r_addr + ADDR_WIDTH'(32'(r_m_num) << BPW_LOG);
                        r_remaining <= r_remaining - NW'(r_m_num);
                        r_state     <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    if (!i_master_ready) r_state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (i_master_ready) begin
                        r_msgs  <= r_msgs | i_master_msgs;
                        r_state <= (r_remaining != '0) ? S_CALC : S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_req_ready             = (r_state == S_IDLE);
    assign o_busy                  = r_busy;
    assign o_done                  = r_done;
    assign o_msgs                  = r_msgs;
    assign o_master_trigger        = w_fire;
    assign o_master_clear_messages = w_fire;
    assign o_master_num_data_words = r_m_num;
    assign o_master_base_address   = r_m_addr;
    assign o_master_direction      = r_m_dir;

endmodule

// File: tb/tb_axi4_master_cmd_seq.sv
// Self-checking bench for axi4_master_cmd_seq: a behavioural axi4_master model answers triggers,
// and each request's chunk list and message OR are predicted from address arithmetic.
module tb_axi4_master_cmd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_direction = 1'b0;
    logic [14:0] i_req_base_address = '0;
    logic [15:0] i_req_num_words = '0;
    logic        o_busy;
    logic        o_done;
    logic [7:0]  o_msgs;
    logic        i_master_ready = 1'b1;
    logic        o_master_trigger;
    logic [8:0]  o_master_num_data_words;
    logic [14:0] o_master_base_address;
    logic        o_master_direction;
    logic [7:0]  i_master_msgs = '0;
    logic        o_master_clear_messages;

    always #5 clk = ~clk;

    axi4_master_cmd_seq dut (
        .clk                     (clk),
        .rst                     (rst),
        .i_req_valid             (i_req_valid),
        .o_req_ready             (o_req_ready),
        .i_req_direction         (i_req_direction),
        .i_req_base_address      (i_req_base_address),
        .i_req_num_words         (i_req_num_words),
        .o_busy                  (o_busy),
        .o_done                  (o_done),
        .o_msgs                  (o_msgs),
        .i_master_ready          (i_master_ready),
        .o_master_trigger        (o_master_trigger),
        .o_master_num_data_words (o_master_num_data_words),
        .o_master_base_address   (o_master_base_address),
        .o_master_direction      (o_master_direction),
        .i_master_msgs           (i_master_msgs),
        .o_master_clear_messages (o_master_clear_messages)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Master model state and trigger log
    int          cyc = 0;
    logic        m_trig_seen = 1'b0;
    int          m_hold = 0;
    int          m_busy = 0;
    int          m_busy_lo = 1;
    int          m_busy_hi = 4;
    int          m_chunk_idx = 0;
    int          ready_rise_cyc = -1;
    logic [7:0]  m_plan [64];
    logic [14:0] q_addr [$];
    int          q_num  [$];
    logic        q_dir  [$];
    logic        q_clr  [$];
    int          q_cyc  [$];
    int          clr_count = 0;

    // Inputs change on the falling edge; the comb trigger is sampled 1 ns later, as the DUT will see it.
    always @(negedge clk) begin
        cyc++;
        if (m_trig_seen) begin
            m_trig_seen    = 1'b0;
            i_master_ready = 1'b0;
            i_master_msgs  = '0;
            m_busy         = $urandom_range(m_busy_hi, m_busy_lo);
        end else if (m_hold > 0) begin
            m_hold--;
            if (m_hold == 0) begin
                i_master_ready = 1'b1;
                ready_rise_cyc = cyc;
            end
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                i_master_ready = 1'b1;
                if (m_chunk_idx > 0 && m_chunk_idx <= 64) i_master_msgs = m_plan[m_chunk_idx-1];
            end
        end
        #1;
        if (o_master_trigger === 1'b1) begin
            q_addr.push_back(o_master_base_address);
            q_num.push_back(int'(o_master_num_data_words));
            q_dir.push_back(o_master_direction);
            q_clr.push_back(o_master_clear_messages);
            q_cyc.push_back(cyc);
            m_trig_seen = 1'b1;
            m_chunk_idx++;
        end
        if (o_master_clear_messages === 1'b1) clr_count++;
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic clear_plan();
        for (int k = 0; k < 64; k++) m_plan[k] = '0;
    endtask

    // Runs one request end to end and compares the trigger log against the chunking rules.
    task automatic run_req(input logic [14:0] a, input int n, input logic dir,
                           input int hold, input bit stray, input string name);
        logic [14:0] ea [$];
        int          en [$];
        logic [14:0] ma;
        logic [7:0]  exp_msgs;
        int          rem, room, c, cycles, bad;
        ma = a;
        rem = n;
        exp_msgs = '0;
        while (rem > 0) begin
            room = 4096 - (int'(ma) % 4096);
            c = (rem < 256) ? rem : 256;
            if (c > room) c = room;
            ea.push_back(ma);
            en.push_back(c);
            ma = ma + 15'(c);
            rem -= c;
        end
        for (int k = 0; k < en.size(); k++) exp_msgs |= m_plan[k];

        q_addr.delete(); q_num.delete(); q_dir.delete(); q_clr.delete(); q_cyc.delete();
        clr_count = 0;
        m_chunk_idx = 0;
        if (hold > 0) begin
            i_master_ready = 1'b0;
            m_hold = hold;
        end
        i_req_valid = 1'b1;
        i_req_base_address = a;
        i_req_num_words = 16'(n);
        i_req_direction = dir;
        n_tests++;
        if (o_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s req_ready_idle: got %b expected 1", name, o_req_ready);
        end
        step();
        i_req_valid = 1'b0;
        cycles = 1;
        n_tests++;
        if (o_busy !== 1'b1 || o_msgs !== 8'h00) begin
            n_fail++; $display("FAIL %s after_accept: busy=%b msgs=%h expected busy=1 msgs=00", name, o_busy, o_msgs);
        end
        bad = 0;
        while (o_done !== 1'b1 && cycles < 4000) begin
            if (stray && cycles <= 10) begin
                i_req_valid = 1'b1;
                i_req_base_address = ~a;
                i_req_num_words = 16'd5;
                if (o_req_ready !== 1'b0) bad++;
            end else begin
                i_req_valid = 1'b0;
            end
            step();
            cycles++;
        end
        i_req_valid = 1'b0;
        n_tests++;
        if (o_done !== 1'b1) begin
            n_fail++; $display("FAIL %s done_timeout: got o_done=%b after %0d cycles expected 1", name, o_done, cycles);
        end
        if (stray) begin
            n_tests++;
            if (bad != 0) begin
                n_fail++; $display("FAIL %s stray_req_ready: got %0d ready cycles expected 0", name, bad);
            end
        end
        if (n == 0) begin
            n_tests++;
            if (cycles != 2) begin
                n_fail++; $display("FAIL %s zero_latency: got %0d expected 2", name, cycles);
            end
        end
        n_tests++;
        if (o_busy !== 1'b0 || o_msgs !== exp_msgs) begin
            n_fail++; $display("FAIL %s at_done: busy=%b msgs=%h expected busy=0 msgs=%h", name, o_busy, o_msgs, exp_msgs);
        end
        n_tests++;
        if (q_addr.size() != ea.size() || clr_count != ea.size()) begin
            n_fail++; $display("FAIL %s chunk_count: got triggers=%0d clears=%0d expected %0d", name, q_addr.size(), clr_count, ea.size());
        end else begin
            for (int k = 0; k < ea.size(); k++) begin
                n_tests++;
                if (q_addr[k] !== ea[k] || q_num[k] != en[k] || q_dir[k] !== dir || q_clr[k] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s chunk%0d: got %0d@%h dir=%b clr=%b expected %0d@%h dir=%b clr=1",
                             name, k, q_num[k], q_addr[k], q_dir[k], q_clr[k], en[k], ea[k], dir);
                end
            end
        end
        if (hold > 0 && q_cyc.size() > 0) begin
            n_tests++;
            if (q_cyc[0] != ready_rise_cyc) begin
                n_fail++; $display("FAIL %s trigger_after_hold: got cycle %0d expected %0d", name, q_cyc[0], ready_rise_cyc);
            end
        end
        step();
        n_tests++;
        if (o_done !== 1'b0 || o_msgs !== exp_msgs) begin
            n_fail++; $display("FAIL %s done_pulse_width: done=%b msgs=%h expected done=0 msgs=%h", name, o_done, o_msgs, exp_msgs);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_tests++;
        if ({o_req_ready, o_busy, o_done, o_master_trigger, o_master_clear_messages, o_msgs,
             o_master_num_data_words, o_master_base_address, o_master_direction} !== {1'b1, 37'd0}) begin
            n_fail++;
            $display("FAIL reset_values: rdy=%b busy=%b done=%b trig=%b clr=%b msgs=%h num=%0d addr=%h dir=%b expected rdy=1 rest 0",
                     o_req_ready, o_busy, o_done, o_master_trigger, o_master_clear_messages, o_msgs,
                     o_master_num_data_words, o_master_base_address, o_master_direction);
        end
    endtask

    task automatic test_split();
        clear_plan();
        run_req(15'h0000, 600, 1'b0, 0, 1'b0, "split600");
    endtask

    task automatic test_boundary();
        clear_plan();
        run_req(15'h0FF0, 40, 1'b1, 0, 1'b0, "boundary");
    endtask

    task automatic test_zero();
        clear_plan();
        run_req(15'h0123, 0, 1'b0, 0, 1'b0, "zero_len");
    endtask

    task automatic test_hold_stray();
        clear_plan();
        run_req(15'h0200, 300, 1'b0, 20, 1'b1, "hold_stray");
    endtask

    task automatic test_msgs();
        clear_plan();
        m_plan[1] = 8'h04;
        run_req(15'h0000, 600, 1'b0, 0, 1'b0, "msgs");
        clear_plan();
        run_req(15'h0040, 8, 1'b1, 0, 1'b0, "msgs_cleared");
    endtask

    task automatic test_reset_mid();
        int waited;
        clear_plan();
        m_busy_lo = 6;
        m_busy_hi = 6;
        q_addr.delete(); q_num.delete(); q_dir.delete(); q_clr.delete(); q_cyc.delete();
        m_chunk_idx = 0;
        i_req_valid = 1'b1;
        i_req_base_address = 15'h0000;
        i_req_num_words = 16'd600;
        i_req_direction = 1'b0;
        step();
        i_req_valid = 1'b0;
        waited = 0;
        while (q_addr.size() == 0 && waited < 100) begin
            step();
            waited++;
        end
        n_tests++;
        if (q_addr.size() == 0) begin
            n_fail++; $display("FAIL reset_mid_first_trigger: got 0 triggers expected 1");
        end
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_busy = 0;
        m_trig_seen = 1'b0;
        i_master_ready = 1'b1;
        i_master_msgs = '0;
        m_busy_lo = 1;
        m_busy_hi = 4;
        n_tests++;
        if ({o_req_ready, o_busy, o_done, o_master_trigger, o_master_clear_messages, o_msgs,
             o_master_num_data_words, o_master_base_address, o_master_direction} !== {1'b1, 37'd0}) begin
            n_fail++;
            $display("FAIL reset_mid_values: rdy=%b busy=%b done=%b trig=%b clr=%b msgs=%h num=%0d addr=%h dir=%b expected rdy=1 rest 0",
                     o_req_ready, o_busy, o_done, o_master_trigger, o_master_clear_messages, o_msgs,
                     o_master_num_data_words, o_master_base_address, o_master_direction);
        end
        waited = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (o_done === 1'b1 || o_busy !== 1'b0) waited++;
        end
        n_tests++;
        if (waited != 0 || q_addr.size() != 1) begin
            n_fail++; $display("FAIL reset_mid_quiet: got %0d active cycles, %0d triggers expected 0, 1", waited, q_addr.size());
        end
        run_req(15'h0100, 10, 1'b0, 0, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        logic [14:0] a;
        int          n;
        logic        dir;
        for (int it = 0; it < 8; it++) begin
            clear_plan();
            for (int k = 0; k < 16; k++)
                if ($urandom_range(3, 0) == 0) m_plan[k] = 8'(1 << $urandom_range(7, 0));
            if (it == 0) begin
                a = 15'h7F80;
                n = 300;
            end else begin
                a = 15'($urandom_range(32767, 0));
                n = ($urandom_range(5, 0) == 0) ? 0 : $urandom_range(1200, 1);
            end
            dir = 1'($urandom_range(1, 0));
            run_req(a, n, dir, 0, 1'b0, $sformatf("random%0d", it));
        end
    endtask

    initial begin
        clear_plan();
        test_reset();
        test_split();
        test_boundary();
        test_zero();
        test_hold_stray();
        test_msgs();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
